// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes and FSM states.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/muldiv.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers.
// Datapath runs on magnitudes; sign correction is applied in the FIX cycle.
module muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hilo_we,
  input  logic             hilo_sel,
  input  logic [WIDTH-1:0] hilo_wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  md_state_e          state, state_nxt;
  md_op_e             op_q;
  logic [WIDTH-1:0]   opa;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   rs_raw;
  logic [2*WIDTH-1:0] acc, acc_step;
  logic [CW-1:0]      count;
  logic               neg_res, neg_rem, div_zero;
  logic               is_div;

  logic               sgn, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;

  logic [WIDTH:0]     mul_sum, div_diff;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign is_div = (op_q == MD_DIV) || (op_q == MD_DIVU);
  assign busy   = (state != IDLE);

  always_comb begin
    sgn   = (md_op_e'(op) == MD_MULT) || (md_op_e'(op) == MD_DIV);
    a_neg = sgn & rs_data[WIDTH-1];
    b_neg = sgn & rt_data[WIDTH-1];
    a_mag = abs_val(rs_data, a_neg);
    b_mag = abs_val(rt_data, b_neg);
  end

  // One radix-2 step: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opa} : '0);
    div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opa};
    div_rem  = div_diff[WIDTH] ? acc[2*WIDTH-2:WIDTH-1] : div_diff[WIDTH-1:0];
    if (is_div) acc_step = {div_rem, acc[WIDTH-2:0], ~div_diff[WIDTH]};
    else        acc_step = {mul_sum, acc[WIDTH-1:1]};
  end

  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    q_fix    = abs_val(acc[WIDTH-1:0], neg_res);
    r_fix    = abs_val(acc[2*WIDTH-1:WIDTH], neg_rem);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (count == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      acc      <= '0;
      opa      <= '0;
      rs_raw   <= '0;
      count    <= '0;
      op_q     <= MD_MULT;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q     <= md_op_e'(op);
            count    <= '0;
            rs_raw   <= rs_data;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= (rt_data == '0);
            if (op[1]) begin
              opa <= b_mag;
              acc <= {{WIDTH{1'b0}}, a_mag};
            end else begin
              opa <= a_mag;
              acc <= {{WIDTH{1'b0}}, b_mag};
            end
          end else if (hilo_we) begin
            if (hilo_sel) hi <= hilo_wdata;
            else          lo <= hilo_wdata;
          end
        end
        RUN: begin
          acc   <= acc_step;
          count <= count + 1'b1;
        end
        FIX: begin
          done <= 1'b1;
          if (!is_div) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (div_zero) begin
            hi <= rs_raw;
            lo <= '1;
          end else begin
            hi <= r_fix;
            lo <= q_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: directed table, busy-phase corner sequences, random vs. model.
module tb_muldiv;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_data = '0, rt_data = '0;
  logic        hilo_we = 1'b0, hilo_sel = 1'b0;
  logic [31:0] hilo_wdata = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .hilo_we(hilo_we), .hilo_sel(hilo_sel), .hilo_wdata(hilo_wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin p = sa * sb; return p; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; return p; end
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb; r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Called just after a clock edge; start is sampled by the next edge (E0).
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 60) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
    end
  endtask

  vec_t vecs[8];
  int n;
  logic [63:0] exp;

  initial begin
    vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
    vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg3x7"};
    vecs[2] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minxmin"};
    vecs[3] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2"};
    vecs[4] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        "divu_100by7"};
    vecs[5] = '{2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, "divu_by0"};
    vecs[6] = '{2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_by0"};
    vecs[7] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf"};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hilo", {hi, lo}, 64'h0);

    foreach (vecs[i]) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      check({vecs[i].name, "_busy"}, busy, 1);
      wait_done(n);
      check({vecs[i].name, "_lat"}, n, 33);
      check({vecs[i].name, "_busy_at_done"}, busy, 0);
      check({vecs[i].name, "_hi"}, hi, vecs[i].hi);
      check({vecs[i].name, "_lo"}, lo, vecs[i].lo);
      @(posedge clk); #1;
      check({vecs[i].name, "_done_pulse"}, done, 0);
    end

    // start + hilo_we arriving mid-operation are both ignored
    launch(2'b11, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    op = 2'b01; rs_data = 32'd5; rt_data = 32'd5; start = 1'b1;
    hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'h1234;
    @(posedge clk); #1;
    start = 1'b0; hilo_we = 1'b0;
    check("busy_mid", busy, 1);
    wait_done(n);
    check("busy_ign_lat", n + 10, 33);
    check("busy_ign_hilo", {hi, lo}, {32'd2, 32'd14});

    // MTHI in idle
    hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'h1234;
    @(posedge clk); #1;
    hilo_we = 1'b0;
    check("mthi", {hi, lo}, {32'h1234, 32'd14});

    // start wins over a same-cycle MTLO
    op = 2'b01; rs_data = 32'd3; rt_data = 32'd4; start = 1'b1;
    hilo_we = 1'b1; hilo_sel = 1'b0; hilo_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0; hilo_we = 1'b0;
    check("start_wins_busy", busy, 1);
    check("start_wins_lo", lo, 32'd14);
    wait_done(n);
    check("start_wins_res", {hi, lo}, {32'd0, 32'd12});

    // reset mid-operation aborts and clears
    launch(2'b01, 32'hFFFF_FFFF, 32'h1234_5678);
    repeat (14) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("midrst_state", {busy, done}, 2'b00);
    check("midrst_hilo", {hi, lo}, 64'h0);
    launch(2'b01, 32'd3, 32'd4);
    wait_done(n);
    check("post_rst_lat", n, 33);
    check("post_rst_res", {hi, lo}, {32'd0, 32'd12});

    // randomized operations against the arithmetic model
    for (int k = 0; k < 30; k++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 300)));
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 1000)) - 32'd500;
      exp = model(ro, ra, rb);
      launch(ro, ra, rb);
      wait_done(n);
      check($sformatf("rand%0d_op%0d_%h_%h", k, ro, ra, rb), {hi, lo}, exp);
      check($sformatf("rand%0d_lat", k), n, 33);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
